// File: rtl/reg_view_selector.sv
// Register-select feeder for the 7-seg display controller: debounced Next/Prev stepping mod 16,
// or a synchronised switch index in direct mode. Optional auto-scan under REG_VIEW_AUTOSCAN_EN.

module reg_view_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_W            = 19
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw_n,
    output logic press
);
    logic [1:0]      sync;
    logic            synced;
    logic            db;
    logic [DB_W-1:0] cnt;

    assign synced = sync[1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync  <= 2'b11;
            db    <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], raw_n};
            press <= 1'b0;
            if (synced == db) begin
                cnt <= '0;
            end else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                // Accept the new level; only a 1->0 (press) edge produces a pulse.
                db    <= synced;
                cnt   <= '0;
                press <= ~synced;
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end
    end
endmodule

module reg_view_selector #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_W            = 19,
    parameter int SCAN_PERIOD     = 50000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       btn_next_n,
    input  logic       btn_prev_n,
    input  logic       direct_mode,
    input  logic [3:0] sw_direct,
`ifdef REG_VIEW_AUTOSCAN_EN
    input  logic       auto_scan,
`endif
    output logic [3:0] sel,
    output logic       sel_changed
);
    localparam int NUM_BTN = 2;

    logic [NUM_BTN-1:0]      btn_raw_n;
    logic [NUM_BTN-1:0]      press;     // [0] next, [1] prev
    logic [1:0]              dm_sync;
    logic [1:0][3:0]         sw_sync;
    logic                    dm_s;
    logic [3:0]              sw_s;
    logic                    step_up;
    logic                    step_dn;
    logic                    scan_step;
    logic [3:0]              sel_nxt;

    assign btn_raw_n = {btn_prev_n, btn_next_n};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        reg_view_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .DB_W           (DB_W)
        ) u_db (
            .clk   (clk),
            .resetn(resetn),
            .raw_n (btn_raw_n[g]),
            .press (press[g])
        );
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dm_sync <= 2'b00;
            sw_sync <= '0;
        end else begin
            dm_sync <= {dm_sync[0], direct_mode};
            sw_sync <= {sw_sync[0], sw_direct};
        end
    end

    assign dm_s    = dm_sync[1];
    assign sw_s    = sw_sync[1];
    // Simultaneous next+prev cancel out.
    assign step_up = press[0] & ~press[1];
    assign step_dn = press[1] & ~press[0];

`ifdef REG_VIEW_AUTOSCAN_EN
    localparam int SCAN_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

    logic [1:0]        as_sync;
    logic [SCAN_W-1:0] scan_cnt;
    logic              scan_tc;

    assign scan_tc = (scan_cnt == SCAN_W'(SCAN_PERIOD - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            as_sync  <= 2'b00;
            scan_cnt <= '0;
        end else begin
            as_sync <= {as_sync[0], auto_scan};
            if (!as_sync[1] || dm_s || (|press) || scan_tc)
                scan_cnt <= '0;
            else
                scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // Any button pulse in the same cycle wins over the scan step.
    assign scan_step = as_sync[1] & ~dm_s & scan_tc & ~(|press);
`else
    assign scan_step = 1'b0;

    // SCAN_PERIOD is consumed only by the auto-scan build.
    if (SCAN_PERIOD < 1) begin : g_scan_period_unused
    end
`endif

    always_comb begin
        sel_nxt = sel;
        if (dm_s)
            sel_nxt = sw_s;
        else if (step_up || scan_step)
            sel_nxt = sel + 4'd1;
        else if (step_dn)
            sel_nxt = sel - 4'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sel         <= 4'd0;
            sel_changed <= 1'b0;
        end else begin
            sel         <= sel_nxt;
            sel_changed <= (sel_nxt != sel);
        end
    end
endmodule
